param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_mem.sv | 24 ++
 rtl/param_sync_fifo.sv | 80 ++++++++
 tb/tb_param_sync_fifo.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants, width helper and operation encoding for the synchronous FIFO.
package fifo_pkg;

  localparam int unsigned DEF_DATA_W = 4;
  localparam int unsigned DEF_DEPTH  = 8;

  // Bits needed to hold values 0..n-1; never less than one bit.
  function automatic int unsigned clog2w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [clog2w(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [clog2w(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]          rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count, threshold flags
// and a sticky overflow flag; storage lives in fifo_mem.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [clog2w(DEPTH+1)-1:0]   count,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic                         overflow
);

  localparam int unsigned PW = clog2w(DEPTH);
  localparam int unsigned CW = clog2w(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  fifo_op_e      op;

  // Ready depends only on registered count, so a pop never frees a slot in the same cycle.
  assign in_ready     = (count != FULL_CNT);
  assign out_valid    = (count != '0);
  assign push         = in_valid && in_ready;
  assign pop          = out_valid && out_ready;
  assign op           = fifo_op_e'({push, pop});
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case (op)
        OP_PUSH: count <= count + CW'(1);
        OP_POP:  count <= count - CW'(1);
        default: ;
      endcase
      if (in_valid && !in_ready) overflow <= 1'b1;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push && !clr),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (out_data)
  );

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench for param_sync_fifo against a queue-based reference model.
module tb_param_sync_fifo;

  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] count;
  logic       almost_full, almost_empty, overflow;

  int errs = 0;
  int checks = 0;

  logic [3:0] q[$];
  logic       ovf_m = 1'b0;

  param_sync_fifo #(
    .DATA_W   (4),
    .DEPTH    (DEPTH),
    .AF_LEVEL (6),
    .AE_LEVEL (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus, apply the FIFO rules to the model at the edge, settle 1 time unit.
  task automatic cycle(input logic v, input logic [3:0] d, input logic r, input logic c);
    bit full, empty;
    in_valid = v; in_data = d; out_ready = r; clr = c;
    @(posedge clk);
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    if (c) begin
      q.delete();
      ovf_m = 1'b0;
    end else begin
      if (v && full) ovf_m = 1'b1;
      if (r && !empty) void'(q.pop_front());
      if (v && !full) q.push_back(d);
    end
    #1;
    in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0;
  endtask

  function automatic logic [8:0] model_vec();
    int n = q.size();
    return {n != DEPTH, n != 0, 4'(n), n >= 6, n <= 2, ovf_m};
  endfunction

  task automatic test_reset();
    #12;
    checks++; if ({in_ready, out_valid, count, almost_full, almost_empty, overflow} !== 9'b1_0_0000_0_1_0) begin
      errs++; $display("FAIL reset_outputs got=%b exp=%b", {in_ready, out_valid, count, almost_full, almost_empty, overflow}, 9'b1_0_0000_0_1_0); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_push();
    logic [3:0] w[3] = '{4'h5, 4'h4, 4'h7};
    cycle(1'b1, w[0], 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_data !== 4'h5) begin
      errs++; $display("FAIL first_word_latency got valid=%b data=%h exp valid=1 data=5", out_valid, out_data); end
    cycle(1'b1, w[1], 1'b0, 1'b0);
    cycle(1'b1, w[2], 1'b0, 1'b0);
    checks++; if (count !== 4'd3 || almost_empty !== 1'b0 || out_data !== 4'h5) begin
      errs++; $display("FAIL three_push got count=%0d ae=%b data=%h exp 3 0 5", count, almost_empty, out_data); end
  endtask

  task automatic test_overflow_drain();
    cycle(1'b0, 4'h0, 1'b0, 1'b1);
    for (int unsigned i = 1; i <= 8; i++) begin
      cycle(1'b1, 4'(i), 1'b0, 1'b0);
      if (i == 5 || i == 6) begin
        checks++; if (almost_full !== (i == 6)) begin
          errs++; $display("FAIL almost_full_at_%0d got=%b exp=%b", i, almost_full, i == 6); end
      end
    end
    checks++; if (in_ready !== 1'b0 || count !== 4'd8 || overflow !== 1'b0) begin
      errs++; $display("FAIL full_state got rdy=%b count=%0d ovf=%b exp 0 8 0", in_ready, count, overflow); end
    cycle(1'b1, 4'hF, 1'b0, 1'b0);
    checks++; if (overflow !== 1'b1 || count !== 4'd8) begin
      errs++; $display("FAIL overflow_set got ovf=%b count=%0d exp 1 8", overflow, count); end
    for (int unsigned i = 1; i <= 8; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 4'(i)) begin
        errs++; $display("FAIL drain_%0d got valid=%b data=%h exp 1 %h", i, out_valid, out_data, 4'(i)); end
      cycle(1'b0, 4'h0, 1'b1, 1'b0);
    end
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    checks++; if (count !== 4'd0 || out_valid !== 1'b0 || overflow !== 1'b1 || almost_empty !== 1'b1) begin
      errs++; $display("FAIL empty_pop got count=%0d valid=%b ovf=%b ae=%b exp 0 0 1 1", count, out_valid, overflow, almost_empty); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] d;
    cycle(1'b0, 4'h0, 1'b0, 1'b1);
    for (int unsigned i = 0; i < 3; i++) cycle(1'b1, 4'($urandom), 1'b0, 1'b0);
    for (int unsigned i = 0; i < 20; i++) begin
      checks++; if (out_data !== q[0]) begin
        errs++; $display("FAIL stream_data_%0d got=%h exp=%h", i, out_data, q[0]); end
      d = 4'($urandom);
      cycle(1'b1, d, 1'b1, 1'b0);
      checks++; if (count !== 4'd3) begin
        errs++; $display("FAIL stream_count_%0d got=%0d exp=3", i, count); end
    end
  endtask

  task automatic test_full_push_pop();
    cycle(1'b0, 4'h0, 1'b0, 1'b1);
    for (int unsigned i = 0; i < DEPTH; i++) cycle(1'b1, 4'(i + 3), 1'b0, 1'b0);
    cycle(1'b1, 4'hA, 1'b1, 1'b0);
    checks++; if (count !== 4'd7 || in_ready !== 1'b1 || out_data !== 4'h4 || overflow !== 1'b1) begin
      errs++; $display("FAIL full_pushpop got count=%0d rdy=%b data=%h ovf=%b exp 7 1 4 1", count, in_ready, out_data, overflow); end
  endtask

  task automatic test_clr();
    cycle(1'b1, 4'hB, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    checks++; if (count !== 4'd5 || overflow !== 1'b1) begin
      errs++; $display("FAIL pre_clr got count=%0d ovf=%b exp 5 1", count, overflow); end
    cycle(1'b1, 4'hC, 1'b1, 1'b1);
    checks++; if (count !== 4'd0 || out_valid !== 1'b0 || overflow !== 1'b0 || in_ready !== 1'b1) begin
      errs++; $display("FAIL clr got count=%0d valid=%b ovf=%b rdy=%b exp 0 0 0 1", count, out_valid, overflow, in_ready); end
  endtask

  task automatic test_async_reset();
    for (int unsigned i = 0; i < 4; i++) cycle(1'b1, 4'(i + 1), 1'b0, 1'b0);
    for (int unsigned i = 0; i < DEPTH; i++) cycle(1'b1, 4'hE, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    q.delete(); ovf_m = 1'b0;
    checks++; if ({in_ready, out_valid, count, almost_full, almost_empty, overflow} !== 9'b1_0_0000_0_1_0) begin
      errs++; $display("FAIL async_reset got=%b exp=%b", {in_ready, out_valid, count, almost_full, almost_empty, overflow}, 9'b1_0_0000_0_1_0); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    cycle(1'b1, 4'h9, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_data !== 4'h9 || count !== 4'd1) begin
      errs++; $display("FAIL post_reset_first got valid=%b data=%h count=%0d exp 1 9 1", out_valid, out_data, count); end
  endtask

  task automatic test_random();
    logic [8:0] exp_vec;
    for (int unsigned i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) < 60), 4'($urandom), ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 3));
      exp_vec = model_vec();
      checks++; if ({in_ready, out_valid, count, almost_full, almost_empty, overflow} !== exp_vec) begin
        errs++; $display("FAIL rand_flags_%0d got=%b exp=%b", i, {in_ready, out_valid, count, almost_full, almost_empty, overflow}, exp_vec); end
      if (q.size() != 0) begin
        checks++; if (out_data !== q[0]) begin
          errs++; $display("FAIL rand_data_%0d got=%h exp=%h", i, out_data, q[0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_push();
    test_overflow_drain();
    test_back_to_back();
    test_full_push_pop();
    test_clr();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
